// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct values, instruction field positions
// and the small decode helpers used by the ID/EX stage.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [5:0]  funct;
  } fields_t;

  typedef struct packed {
    logic mem_read;
    logic reg_write;
  } ctrl_t;

  // imm overlaps rd/shamt/funct; every format's view is sliced unconditionally.
  function automatic fields_t slice_fields(input logic [INSTR_W-1:0] instr);
    fields_t f;
    f.opcode = instr[OP_MSB:OP_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.rt     = instr[RT_MSB:RT_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.shamt  = instr[SH_MSB:SH_LSB];
    f.imm    = instr[IMM_MSB:IMM_LSB];
    f.funct  = instr[FN_MSB:FN_LSB];
    return f;
  endfunction

  function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE:                   c.reg_write = (funct != FN_JR);
      OP_LW, OP_LH, OP_LB: begin
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLTI, OP_LUI, OP_JAL:    c.reg_write = 1'b1;
      default:                    ;
    endcase
    return c;
  endfunction

  // Stores and branches read rt as a source operand, as do all R-type ops.
  function automatic logic uses_rt(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: compares the IF/ID source registers against the
// destination of a load currently sitting in ID/EX.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [5:0]        opcode,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              valid,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              flush,
  input  logic              hold,
  output logic              hz,
  output logic              stall
);

  logic rt_is_src;

  // NOTE: purely combinational; every output is assigned on every path so no latch is inferred.
  always_comb begin
    rt_is_src = uses_rt(opcode);
    hz        = valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                ((ex_rt == rs) | (rt_is_src & (ex_rt == rt)));
    // A flush kills the dependent slot; a hold already freezes upstream.
    stall     = hz & ~flush & ~hold;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 32-bit MIPS core: field slicing, control
// decode, load-use bubble insertion, flush/hold and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        InstrIn,
  input  logic [DATA_W-1:0]  PCPlus4In,
  input  logic               ValidIn,
  input  logic [DATA_W-1:0]  RegData1In,
  input  logic [DATA_W-1:0]  RegData2In,
  input  logic               FlushIn,
  input  logic               HoldIn,
  output logic [5:0]         OpcodeOut,
  output logic [5:0]         FunctOut,
  output logic [REG_AW-1:0]  RsOut,
  output logic [REG_AW-1:0]  RtOut,
  output logic [REG_AW-1:0]  RdOut,
  output logic [4:0]         ShamtOut,
  output logic [15:0]        ImmOut,
  output logic [DATA_W-1:0]  ReadData1Out,
  output logic [DATA_W-1:0]  ReadData2Out,
  output logic [DATA_W-1:0]  PCPlus4Out,
  output logic               ValidOut,
  output logic               MemReadOut,
  output logic               RegWriteOut,
  output logic               StallOut,
  output logic [CNT_W-1:0]   BubbleCount
);

  fields_t f;
  ctrl_t   ctrl;
  logic    hz;

  always_comb begin
    f    = slice_fields(InstrIn);
    ctrl = decode(f.opcode, f.funct);
  end

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .opcode      (f.opcode),
    .rs          (REG_AW'(f.rs)),
    .rt          (REG_AW'(f.rt)),
    .valid       (ValidIn),
    .ex_valid    (ValidOut),
    .ex_mem_read (MemReadOut),
    .ex_rt       (RtOut),
    .flush       (FlushIn),
    .hold        (HoldIn),
    .hz          (hz),
    .stall       (StallOut)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OpcodeOut    <= '0;
      FunctOut     <= '0;
      RsOut        <= '0;
      RtOut        <= '0;
      RdOut        <= '0;
      ShamtOut     <= '0;
      ImmOut       <= '0;
      ReadData1Out <= '0;
      ReadData2Out <= '0;
      PCPlus4Out   <= '0;
      ValidOut     <= 1'b0;
      MemReadOut   <= 1'b0;
      RegWriteOut  <= 1'b0;
      BubbleCount  <= '0;
    end else if (FlushIn || !HoldIn) begin
      // Fields load on flush and bubble too; only the valid/control bits matter then.
      OpcodeOut    <= f.opcode;
      FunctOut     <= f.funct;
      RsOut        <= REG_AW'(f.rs);
      RtOut        <= REG_AW'(f.rt);
      RdOut        <= REG_AW'(f.rd);
      ShamtOut     <= f.shamt;
      ImmOut       <= f.imm;
      ReadData1Out <= RegData1In;
      ReadData2Out <= RegData2In;
      PCPlus4Out   <= PCPlus4In;
      if (FlushIn || hz) begin
        ValidOut    <= 1'b0;
        MemReadOut  <= 1'b0;
        RegWriteOut <= 1'b0;
      end else begin
        ValidOut    <= ValidIn;
        MemReadOut  <= ctrl.mem_read & ValidIn;
        RegWriteOut <= ctrl.reg_write & ValidIn;
      end
      if (!FlushIn && hz && (BubbleCount != '1))
        BubbleCount <= BubbleCount + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 32-bit MIPS core: slices the IF/ID instruction into fields and registers them with operands and control for EX.
- Its registered shamt and imm fields feed the 5-to-32 and 16-to-32 sign extenders in EX.
- Contains the load-use hazard detector (bubble insert plus upstream stall), EX-driven flush, downstream hold and a saturating bubble counter.

Parameters:
- DATA_W, 32: datapath and PC width.
- REG_AW, 5: register address width.
- CNT_W, 16: bubble counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- InstrIn  in  32  instruction from IF/ID.
- PCPlus4In  in  DATA_W  PC+4 from IF/ID.
- ValidIn  in  1  IF/ID slot holds a real instruction.
- RegData1In, RegData2In  in  DATA_W  register file reads for rs and rt.
- FlushIn  in  1  branch/jump resolved taken in EX; kill the incoming slot.
- HoldIn  in  1  EX busy; freeze this stage.
- OpcodeOut  out  6  registered opcode.
- FunctOut  out  6  registered funct.
- RsOut, RtOut, RdOut  out  REG_AW  registered register fields.
- ShamtOut  out  5  registered shamt, to the 5-bit sign extender.
- ImmOut  out  16  registered imm, to the 16-bit sign extender.
- ReadData1Out, ReadData2Out  out  DATA_W  registered operands.
- PCPlus4Out  out  DATA_W  registered PC+4.
- ValidOut  out  1  EX slot valid.
- MemReadOut  out  1  EX instruction is a load.
- RegWriteOut  out  1  EX instruction writes a register.
- StallOut  out  1  combinational: hold PC and IF/ID this cycle.
- BubbleCount  out  CNT_W  count of load-use bubbles inserted; saturates.

Behaviour:
- Reset (asynchronous, any time, including mid-stall): all registered outputs 0, ValidOut=0, BubbleCount=0. StallOut is 0 while Reset is high.
- Field slicing from InstrIn:
  - opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], imm[15:0], funct[5:0].
- Decode (combinational on InstrIn):
  - MemRead for opcodes 100011 (lw), 100001 (lh), 100000 (lb).
  - RegWrite for R-type (opcode 000000) except funct 001000 (jr); for lw/lh/lb; for 001000 addi, 001100 andi, 001101 ori, 001110 xori, 001010 slti, 001111 lui, 000011 jal.
  - usesRt for R-type, 101011 sw, 101001 sh, 101000 sb, 000100 beq, 000101 bne.
- Hazard (combinational):
  - hz = ValidIn & ValidOut & MemReadOut & (RtOut!=0) & ((RtOut==rs) | (usesRt & RtOut==rt)).
  - StallOut = hz & ~FlushIn & ~HoldIn.
- Register update on each rising edge, first match wins:
  - 1 FlushIn: ValidOut=0, MemReadOut=0, RegWriteOut=0; other fields don't-care (implementation loads them normally). Flush overrides hold and hazard.
  - 2 HoldIn: every register keeps its value; StallOut=0 (upstream is stalled by its own hold path).
  - 3 hz: insert bubble. ValidOut=0, MemReadOut=0, RegWriteOut=0. BubbleCount += 1, saturating at all-ones. The instruction stays in IF/ID and re-enters next cycle.
  - 4 otherwise: load all fields. ValidOut=ValidIn. MemReadOut and RegWriteOut = decode AND ValidIn.
- Latency: 1 cycle from InstrIn to outputs. A load-use pair costs exactly 1 bubble: after the bubble, ValidOut=0, so hz deasserts.
- Invalid input (ValidIn=0): never raises a hazard; the slot loads with ValidOut=0 and its controls forced to 0.
- Register $0 as a load destination never causes a stall.

Decomposition:
- Shared package mips_pkg: opcode and funct localparams (OP_RTYPE, OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI, OP_JAL, FN_JR) and instruction field bit positions.
- One sub-module, hazard_detect: combinational hz/StallOut from the IF/ID fields and the ID/EX RtOut, MemReadOut and ValidOut.

Test Plan:
- Reset mid-stream: assert Reset asynchronously between edges -> all outputs 0 immediately, BubbleCount=0, StallOut=0.
- Field slice: InstrIn=0x012A4020 (add $8,$9,$10), ValidIn=1 -> next cycle RsOut=9, RtOut=10, RdOut=8, FunctOut=0x20, RegWriteOut=1, MemReadOut=0.
- Load-use: lw $2,0($1) (0x8C220000) then add $3,$2,$4 (0x00441820) -> StallOut=1 for one cycle, one bubble (ValidOut=0), BubbleCount=1, then the add is registered. Same sequence with destination $0 -> no stall.
- Flush priority: hazard condition present with FlushIn=1 -> StallOut=0, ValidOut=0 next cycle, BubbleCount unchanged.
- Hold: HoldIn=1 for 3 cycles with changing InstrIn -> all outputs frozen, StallOut=0. Release HoldIn -> current input loads.
- Saturation: CNT_W=2, force 5 load-use bubbles -> BubbleCount sticks at 3.
